// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline control blocks.
//   REG_W        architectural register index width
//   REG_ZERO     hard-wired zero register; never a hazard source
//   ZERO_CTRL    all-zero control bundle loaded into ID/EXE on a bubble
//   NOP_INSTR    instruction word loaded into IF/ID on a flush
//   hz_state_t   hazard controller FSM states
//   hz_match()   does a destination collide with an ID-stage source?
package pipe_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  // wb/mem/br controls of the ID/EXE register; a bubble loads all zeros
  typedef struct packed {
    logic wb_en;
    logic mem_read;
    logic mem_write;
    logic br;
  } ctrl_bits_t;

  localparam ctrl_bits_t ZERO_CTRL = '0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  function automatic logic hz_match(
    input logic [REG_W-1:0] dest,
    input logic [REG_W-1:0] src1,
    input logic [REG_W-1:0] src2,
    input logic             two_src
  );
    return (dest != REG_ZERO) &&
           ((dest == src1) || (two_src && (dest == src2)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   rising-edge clock
//   rst   synchronous reset, active-high
//   clr   synchronous clear (same effect as rst)
//   inc   count up by one this cycle
//   cnt   current count; sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the ID/EXE and EXE/MEM pipeline registers.
// Detects load-use (or, without forwarding, any RAW) hazards against the
// in-flight destinations, flushes the front end on a taken branch resolved in
// EXE, and freezes the whole pipe while data memory is not ready.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_valid, id_src1/2,     ID-stage instruction and its sources;
//   id_two_src               id_src2 only counts when id_two_src=1
//   exe_dest/wb_en/mem_read  outputs of the ID/EXE register
//   mem_dest/wb_en           outputs of the EXE/MEM register
//   exe_br_taken             branch taken, resolved in EXE this cycle
//   mem_req, mem_ready       data-memory handshake from the MEM stage
//   hold_pc, hold_if_id      keep PC / IF/ID
//   bubble_id_exe            ID/EXE loads all-zero controls
//   flush_if_id              IF/ID loads NOP
//   hold_all                 freeze every pipeline register
//   stall_cycles             saturating count of cycles with hold_pc=1
//   flush_count              saturating count of taken-branch flushes
//   mem_timeout              sticky: a memory wait ran past MEM_TIMEOUT cycles
//
// States:
//   state    | meaning
//   RUN      | normal flow; hazards and branches handled combinationally
//   MEM_WAIT | data access outstanding; pipe frozen until mem_ready
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int FWD_EN      = 1,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_read,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic             exe_br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             hold_pc,
  output logic             hold_if_id,
  output logic             bubble_id_exe,
  output logic             flush_if_id,
  output logic             hold_all,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout
);

  // Wide enough to hold MEM_TIMEOUT so the saturation point lies past the
  // timeout compare value.
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hz_state_t         state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_stall;
  logic              exe_hz, mem_hz, data_hz;

  assign exe_hz = hz_match(exe_dest, id_src1, id_src2, id_two_src);
  assign mem_hz = hz_match(mem_dest, id_src1, id_src2, id_two_src);

  // With forwarding only a load in EXE cannot be bypassed in time; without it
  // any pending write in EXE or MEM must drain first.
  generate
    if (FWD_EN != 0) begin : g_fwd
      assign data_hz = id_valid && exe_mem_read && exe_hz;
    end else begin : g_nofwd
      assign data_hz = id_valid && ((exe_wb_en && exe_hz) || (mem_wb_en && mem_hz));
    end
  endgenerate

  assign mem_stall = (state == RUN) ? (mem_req && !mem_ready) : !mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    hold_pc       = 1'b0;
    hold_if_id    = 1'b0;
    bubble_id_exe = 1'b0;
    flush_if_id   = 1'b0;
    hold_all      = 1'b0;

    case (state)
      RUN:      if (mem_req && !mem_ready) state_nxt = MEM_WAIT;
      MEM_WAIT: if (mem_ready) state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase

    // Frozen registers mean a pending branch or hazard is simply seen again
    // once memory releases the pipe. A taken branch squashes the ID
    // instruction, so its hazard no longer matters.
    if (mem_stall) begin
      hold_all   = 1'b1;
      hold_pc    = 1'b1;
      hold_if_id = 1'b1;
    end else if (exe_br_taken) begin
      flush_if_id   = 1'b1;
      bubble_id_exe = 1'b1;
    end else if (data_hz) begin
      hold_pc       = 1'b1;
      hold_if_id    = 1'b1;
      bubble_id_exe = 1'b1;
    end
  end

  // The wait count includes the cycle the access first stalls, so it equals
  // the number of frozen cycles so far; it clears as soon as the pipe moves.
  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .clr (!mem_stall),
    .inc (mem_stall),
    .cnt (wait_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (hold_pc),
    .cnt (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (flush_if_id),
    .cnt (flush_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_timeout <= 1'b0;
    end else if ((state == MEM_WAIT) && !mem_ready && (wait_cnt == WAIT_LAST)) begin
      mem_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  import pipe_pkg::*;

  localparam int CW_F = 32;
  localparam int CW_N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             id_valid, id_two_src;
  logic [REG_W-1:0] id_src1, id_src2, exe_dest, mem_dest;
  logic             exe_wb_en, exe_mem_read, mem_wb_en;
  logic             exe_br_taken, mem_req, mem_ready;

  logic            f_hold_pc, f_hold_if_id, f_bubble, f_flush, f_hold_all, f_tmo;
  logic [CW_F-1:0] f_stall, f_flcnt;
  logic            n_hold_pc, n_hold_if_id, n_bubble, n_flush, n_hold_all, n_tmo;
  logic [CW_N-1:0] n_stall, n_flcnt;

  hazard_ctrl #(.FWD_EN(1), .MEM_TIMEOUT(4), .CNT_W(CW_F)) u_fwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .exe_mem_read(exe_mem_read), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .exe_br_taken(exe_br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .hold_pc(f_hold_pc), .hold_if_id(f_hold_if_id), .bubble_id_exe(f_bubble),
    .flush_if_id(f_flush), .hold_all(f_hold_all), .stall_cycles(f_stall),
    .flush_count(f_flcnt), .mem_timeout(f_tmo)
  );

  hazard_ctrl #(.FWD_EN(0), .MEM_TIMEOUT(64), .CNT_W(CW_N)) u_nofwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .exe_mem_read(exe_mem_read), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .exe_br_taken(exe_br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .hold_pc(n_hold_pc), .hold_if_id(n_hold_if_id), .bubble_id_exe(n_bubble),
    .flush_if_id(n_flush), .hold_all(n_hold_all), .stall_cycles(n_stall),
    .flush_count(n_flcnt), .mem_timeout(n_tmo)
  );

  // ctrl vector order: {hold_pc, hold_if_id, bubble_id_exe, flush_if_id, hold_all}
  localparam logic [4:0] C_IDLE  = 5'b00000;
  localparam logic [4:0] C_HZ    = 5'b11100;
  localparam logic [4:0] C_BR    = 5'b00110;
  localparam logic [4:0] C_MEM   = 5'b11001;

  typedef struct {
    string       tag;
    int          dut;
    logic [4:0]  ctrl;
    logic [31:0] stall;
    logic [31:0] flush;
    logic        tmo;
  } exp_t;

  exp_t sb[$];
  int n_asserts = 0;
  int n_fail    = 0;

  // Reference model state, advanced from the bench's own expected controls.
  logic [31:0] m_stall [2];
  logic [31:0] m_flush [2];
  logic        m_tmo   [2];
  logic [31:0] m_max   [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_stall[i] = '0;
      m_flush[i] = '0;
      m_tmo[i]   = 1'b0;
    end
  endtask

  task automatic idle();
    rst          = 1'b0;
    id_valid     = 1'b0;
    id_two_src   = 1'b0;
    id_src1      = '0;
    id_src2      = '0;
    exe_dest     = '0;
    exe_wb_en    = 1'b0;
    exe_mem_read = 1'b0;
    mem_dest     = '0;
    mem_wb_en    = 1'b0;
    exe_br_taken = 1'b0;
    mem_req      = 1'b0;
    mem_ready    = 1'b1;
  endtask

  task automatic check_pop();
    exp_t        e;
    logic [4:0]  oc;
    logic [31:0] os, of;
    logic        ot;
    n_asserts++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty observed size 0 expected >0");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.dut == 0) begin
        oc = {f_hold_pc, f_hold_if_id, f_bubble, f_flush, f_hold_all};
        os = 32'(f_stall);
        of = 32'(f_flcnt);
        ot = f_tmo;
      end else begin
        oc = {n_hold_pc, n_hold_if_id, n_bubble, n_flush, n_hold_all};
        os = 32'(n_stall);
        of = 32'(n_flcnt);
        ot = n_tmo;
      end
      n_asserts++;
      assert (oc === e.ctrl) else begin
        n_fail++;
        $error("FAIL %s/d%0d ctrl observed %b expected %b", e.tag, e.dut, oc, e.ctrl);
      end
      n_asserts++;
      assert (os === e.stall) else begin
        n_fail++;
        $error("FAIL %s/d%0d stall_cycles observed %0d expected %0d", e.tag, e.dut, os, e.stall);
      end
      n_asserts++;
      assert (of === e.flush) else begin
        n_fail++;
        $error("FAIL %s/d%0d flush_count observed %0d expected %0d", e.tag, e.dut, of, e.flush);
      end
      n_asserts++;
      assert (ot === e.tmo) else begin
        n_fail++;
        $error("FAIL %s/d%0d mem_timeout observed %b expected %b", e.tag, e.dut, ot, e.tmo);
      end
    end
  endtask

  // Inputs are already driven (just after a falling edge). Push what each
  // instance should show this cycle, compare once outputs have settled, then
  // advance the model by the cycle's effect on the counters.
  task automatic step(input string tag, input logic [4:0] ef, input logic [4:0] en);
    logic [4:0] ev [2];
    exp_t e;
    ev[0] = ef;
    ev[1] = en;
    for (int d = 0; d < 2; d++) begin
      e.tag   = tag;
      e.dut   = d;
      e.ctrl  = ev[d];
      e.stall = m_stall[d];
      e.flush = m_flush[d];
      e.tmo   = m_tmo[d];
      sb.push_back(e);
    end
    #1;
    check_pop();
    check_pop();
    for (int d = 0; d < 2; d++) begin
      if (ev[d][4] && (m_stall[d] != m_max[d])) m_stall[d] = m_stall[d] + 1;
      if (ev[d][1] && (m_flush[d] != m_max[d])) m_flush[d] = m_flush[d] + 1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    m_max[0] = 32'hFFFF_FFFF;
    m_max[1] = 32'(4'hF);
    model_reset();
    @(negedge clk);
    do_reset();

    idle();
    step("reset_idle", C_IDLE, C_IDLE);

    // load-use against EXE, then the load has moved to MEM
    idle();
    id_valid = 1; id_src1 = 5; exe_dest = 5; exe_wb_en = 1; exe_mem_read = 1;
    step("load_use", C_HZ, C_HZ);
    idle();
    id_valid = 1; id_src1 = 5; mem_dest = 5; mem_wb_en = 1;
    step("load_in_mem", C_IDLE, C_HZ);
    idle();
    step("after_load_use", C_IDLE, C_IDLE);

    // register 0 and unread src2 never hazard
    idle();
    id_valid = 1; id_src1 = 0; exe_dest = 0; exe_wb_en = 1; exe_mem_read = 1;
    step("dest_zero", C_IDLE, C_IDLE);
    idle();
    id_valid = 1; id_src1 = 3; id_src2 = 5; id_two_src = 0;
    exe_dest = 5; exe_wb_en = 1; exe_mem_read = 1;
    step("src2_unread", C_IDLE, C_IDLE);
    id_two_src = 1;
    step("src2_read", C_HZ, C_HZ);
    id_valid = 0;
    step("id_invalid", C_IDLE, C_IDLE);

    // RAW against MEM only matters without forwarding
    idle();
    id_valid = 1; id_src1 = 1; id_src2 = 7; id_two_src = 1; mem_dest = 7; mem_wb_en = 1;
    step("raw_mem_src2", C_IDLE, C_HZ);

    // taken branch beats a simultaneous load-use
    idle();
    id_valid = 1; id_src1 = 5; exe_dest = 5; exe_wb_en = 1; exe_mem_read = 1;
    exe_br_taken = 1;
    step("branch_over_hz", C_BR, C_BR);
    idle();
    step("after_branch", C_IDLE, C_IDLE);

    // memory stall: 5 cycles low, branch during the stall is held off
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      idle();
      mem_req = 1; mem_ready = 0;
      if (i == 2) exe_br_taken = 1;
      if (i == 5) m_tmo[0] = 1'b1;
      step($sformatf("mem_stall_%0d", i), C_MEM, C_MEM);
    end
    idle();
    mem_req = 1; mem_ready = 1;
    step("mem_ready", C_IDLE, C_IDLE);
    idle();
    step("after_mem", C_IDLE, C_IDLE);

    // timeout sticks, then reset in MEM_WAIT returns to RUN
    do_reset();
    step("reset_clears", C_IDLE, C_IDLE);
    for (int i = 1; i <= 6; i++) begin
      idle();
      mem_req = (i == 1); mem_ready = 0;
      if (i == 5) m_tmo[0] = 1'b1;
      step($sformatf("timeout_%0d", i), C_MEM, C_MEM);
    end
    idle();
    mem_ready = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    model_reset();
    idle();
    step("reset_in_wait", C_IDLE, C_IDLE);

    // stall counter saturation on the narrow instance
    for (int i = 0; i < 20; i++) begin
      idle();
      id_valid = 1; id_src1 = 3; exe_dest = 3; exe_wb_en = 1;
      step($sformatf("sat_%0d", i), C_IDLE, C_HZ);
    end
    idle();
    step("sat_final", C_IDLE, C_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
